// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit: instruction prefetch front end between the CPU ROM port
// and a variable-latency instruction memory. It prefetches sequentially into a
// DEPTH-entry tagged FIFO and serves hits combinationally. On a miss it stalls
// the CPU, flushes the FIFO and redirects fetch to the missed address.
// Optional hit/miss statistics counters are enabled by INST_PREFETCH_STATS_EN.
module inst_prefetch_unit #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4,
   parameter int ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [DATA_W-1:0] cpu_inst_o,
   output logic              cpu_valid_o,
   output logic              stall_req_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i
`ifdef INST_PREFETCH_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              stale_q, stale_d;

   logic [ADDR_W-1:0] tag_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic              ce, empty, ack, hit, bypass, miss, redirect, push, pop;
   logic [ADDR_W-1:0] expect_addr;

   // CPU-side decode: hit, bypass, miss/redirect and FIFO/fetch-pointer updates
   always_comb begin
      ce          = cpu_ce_i & rst;
      empty       = (count_q == '0);
      ack         = (state_q == REQ) & mem_ack_i;
      expect_addr = empty ? fetch_ptr_q : tag_q[rd_ptr_q];
      hit         = ce & ~empty & (tag_q[rd_ptr_q] == cpu_addr_i);
      bypass      = ce & empty & ack & ~stale_q & (mem_addr_q == cpu_addr_i);
      miss        = ce & ~hit & ~bypass;
      // a miss on the expected address just waits; anything else redirects
      redirect    = miss & (cpu_addr_i != expect_addr);
      pop         = hit;
      // a redirect in the ack cycle makes the returning data stale as well
      push        = ack & ~stale_q & ~bypass & ~redirect;

      rd_ptr_d = redirect ? '0 : rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = redirect ? '0 : wr_ptr_q + PTR_W'(push);
      count_d  = redirect ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

      fetch_ptr_d = fetch_ptr_q;
      if (redirect)
         fetch_ptr_d = cpu_addr_i;
      else if (ack && !stale_q)
         fetch_ptr_d = fetch_ptr_q + ADDR_W'(ADDR_STEP);

      // the in-flight request can't be withdrawn, so mark its data stale
      stale_d = stale_q;
      if (redirect)
         stale_d = (state_q == REQ) & ~mem_ack_i;
      else if (ack)
         stale_d = 1'b0;
   end

   // Memory FSM next state: issue whenever a FIFO slot can be reserved
   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      if (state_q == IDLE || ack) begin
         if (count_d < CNT_W'(DEPTH)) begin
            state_d    = REQ;
            mem_addr_d = fetch_ptr_d;
         end else begin
            state_d    = IDLE;
         end
      end
   end

   // Memory FSM outputs: request held stable from a register until ack
   always_comb begin
      mem_req_o  = (state_q == REQ);
      mem_addr_o = mem_addr_q;
   end

   // CPU-side outputs
   always_comb begin
      cpu_valid_o = hit | bypass;
      stall_req_o = miss;
      cpu_inst_o  = '0;
      if (hit)
         cpu_inst_o = data_q[rd_ptr_q];
      else if (bypass)
         cpu_inst_o = mem_data_i;
   end

   // State register and FIFO control with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         fetch_ptr_q <= '0;
         mem_addr_q  <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         stale_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_ptr_q <= fetch_ptr_d;
         mem_addr_q  <= mem_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         stale_q     <= stale_d;
      end
   end

   // FIFO storage; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         tag_q[wr_ptr_q]  <= mem_addr_q;
         data_q[wr_ptr_q] <= mem_data_i;
      end
   end

`ifdef INST_PREFETCH_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   // Saturating counters: served cycles and redirects
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if ((hit || bypass) && hit_cnt_q != '1)
         hit_cnt_d = hit_cnt_q + 32'd1;
      if (redirect && miss_cnt_q != '1)
         miss_cnt_d = miss_cnt_q + 32'd1;
   end

   // Statistics registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// tb_inst_prefetch_unit: directed scenarios plus randomized CPU/memory traffic
// for inst_prefetch_unit (ADDR_W=8 so address wrap is reachable), checked every
// cycle against a queue-level reference model.
module tb_inst_prefetch_unit;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_ce_i = 1'b0;
   logic [AW-1:0] cpu_addr_i = '0;
   logic [DW-1:0] cpu_inst_o;
   logic          cpu_valid_o, stall_req_o, mem_req_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_ack_i = 1'b0;
   logic [DW-1:0] mem_data_i = '0;
`ifdef INST_PREFETCH_STATS_EN
   logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

   always #5 clk = ~clk;

   inst_prefetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_STEP(4)) dut (
      .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
      .cpu_inst_o(cpu_inst_o), .cpu_valid_o(cpu_valid_o), .stall_req_o(stall_req_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
      .mem_data_i(mem_data_i)
`ifdef INST_PREFETCH_STATS_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // instruction memory contents: a fixed function of the address
   function automatic logic [31:0] memw(input logic [AW-1:0] a);
      return 32'h9E3779B9 * ({24'h0, a} + 32'd1);
   endfunction

   // memory responder state
   bit            busy = 0;
   int            left = 0;
   int            lat_fix = 2;
   bit            lat_rnd = 0;
   int            acks = 0;
   logic [AW-1:0] req_log[$];

   // reference model: prefetched addresses in order, next fetch address,
   // the single outstanding request and whether its data is stale
   logic [AW-1:0] m_q[$];
   logic [AW-1:0] m_fptr = '0, m_oaddr = '0;
   bit            m_out = 0, m_stale = 0;
   int            m_hits = 0, m_miss = 0;

   logic          obs_v = 0, obs_s = 0, obs_ack = 0;
   logic [DW-1:0] obs_i = '0;

   // one clock cycle, entered and left at the negative edge
   task automatic cycle();
      bit hit, byp, redir, ack, ev, es;
      logic [31:0] ei;
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      if (mem_req_o !== 1'b1) busy = 0;
      else begin
         if (!busy) begin
            busy = 1;
            left = lat_rnd ? int'($urandom_range(1, 4)) : lat_fix;
            req_log.push_back(mem_addr_o);
         end
         left--;
         if (left <= 0) begin
            mem_ack_i  = 1'b1;
            mem_data_i = memw(mem_addr_o);
            busy = 0;
            acks++;
         end
      end
      #1;
      hit = 0; byp = 0; redir = 0;
      if (rst && cpu_ce_i) begin
         if (m_q.size() > 0 && m_q[0] == cpu_addr_i) hit = 1;
         else if (m_q.size() == 0 && m_out && mem_ack_i && !m_stale && m_oaddr == cpu_addr_i) byp = 1;
         else redir = (m_q.size() > 0) || (cpu_addr_i != m_fptr);
      end
      ev = hit | byp;
      es = rst & cpu_ce_i & ~ev;
      ei = hit ? memw(m_q[0]) : (byp ? memw(m_oaddr) : 32'h0);
      if (rst) begin
         chk("mem_req", mem_req_o, m_out);
         if (m_out) chk("mem_addr", mem_addr_o, m_oaddr);
      end
      chk("cpu_valid", cpu_valid_o, ev);
      chk("stall_req", stall_req_o, es);
      chk("cpu_inst", cpu_inst_o, ei);
      obs_v = cpu_valid_o; obs_s = stall_req_o; obs_i = cpu_inst_o; obs_ack = mem_ack_i;
      if (!rst) begin
         m_q.delete(); m_fptr = '0; m_out = 0; m_stale = 0; m_hits = 0; m_miss = 0;
      end else begin
         ack = m_out && mem_ack_i;
         if (ev) m_hits++;
         if (redir) m_miss++;
         if (hit) void'(m_q.pop_front());
         if (redir) m_q.delete();
         if (ack) begin
            if (!m_stale && !byp && !redir) m_q.push_back(m_oaddr);
            if (!m_stale && !redir) m_fptr = m_fptr + 8'd4;
            m_out = 0;
         end
         if (redir) begin
            m_fptr  = cpu_addr_i;
            m_stale = m_out;
         end else if (ack) m_stale = 0;
         if (!m_out && m_q.size() < DEPTH) begin
            m_out = 1;
            m_oaddr = m_fptr;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_vld(input int lim);
      obs_v = 0;
      for (int i = 0; i < lim && !obs_v; i++) cycle();
   endtask

   int            stalls;
   logic [AW-1:0] pc;
   logic [AW-1:0] first;

   initial begin
      // reset state
      rst = 1'b0; cpu_ce_i = 1'b0;
      repeat (2) cycle();
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_valid", cpu_valid_o, 0);
      chk("rst_stall", stall_req_o, 0);
      chk("rst_inst", cpu_inst_o, 0);

      // cold start at 0x0, ack latency 2, first word via bypass
      rst = 1'b1; cpu_ce_i = 1'b1; cpu_addr_i = 8'h00; lat_fix = 2;
      req_log.delete();
      stalls = 0; obs_v = 0;
      for (int i = 0; i < 20 && !obs_v; i++) begin
         cycle();
         if (obs_s) stalls++;
      end
      chk("cold_valid", obs_v, 1);
      chk("cold_stalls", stalls, 2);
      chk("cold_inst", obs_i, memw(8'h00));
      chk("cold_on_ack", obs_ack, 1);

      // idle CPU: FIFO fills 0x4..0x10
      cpu_ce_i = 1'b0;
      repeat (12) cycle();
      chk("fill_req_idle", mem_req_o, 0);
      chk("fill_log_n", req_log.size(), 5);
      for (int i = 0; i < 5 && i < req_log.size(); i++)
         chk("fill_log", req_log[i], 4 * i);

      // sequential hits, zero latency
      req_log.delete();
      lat_fix = 4;
      for (int i = 1; i <= 3; i++) begin
         cpu_ce_i = 1'b1; cpu_addr_i = AW'(4 * i);
         cycle();
         chk("seq_valid", obs_v, 1);
         chk("seq_stall", obs_s, 0);
         chk("seq_inst", obs_i, memw(AW'(4 * i)));
      end

      // branch to 0x80 while 0x14 is in flight
      chk("br_req", mem_req_o, 1);
      chk("br_addr_old", mem_addr_o, 8'h14);
      cpu_addr_i = 8'h80;
      wait_vld(40);
      chk("br_valid", obs_v, 1);
      chk("br_inst", obs_i, memw(8'h80));
      chk("br_on_ack", obs_ack, 1);
      chk("br_log_n", req_log.size(), 2);
      if (req_log.size() >= 2) begin
         chk("br_log0", req_log[0], 8'h14);
         chk("br_log1", req_log[1], 8'h80);
      end

      // back-pressure: exactly DEPTH acks with the CPU idle
      cpu_ce_i = 1'b0; lat_fix = 2; acks = 0;
      repeat (20) cycle();
      chk("bp_acks", acks, DEPTH);
      chk("bp_req_idle", mem_req_o, 0);

      // reset with a request in flight and two entries queued
      lat_fix = 6;
      cpu_ce_i = 1'b1;
      cpu_addr_i = 8'h84; cycle();
      cpu_addr_i = 8'h88; cycle();
      chk("mid_pre_req", mem_req_o, 1);
      rst = 1'b0; cpu_addr_i = 8'h8C;
      cycle();
      rst = 1'b1; cpu_ce_i = 1'b0;
      #1;
      chk("mid_req", mem_req_o, 0);
      chk("mid_valid", cpu_valid_o, 0);
      req_log.delete();
      for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
      first = (req_log.size() > 0) ? req_log[0] : 8'hFF;
      chk("mid_first_req", first, 8'h00);

      // address wrap at 0xFC
      lat_fix = 2;
      rst = 1'b0; cycle();
      rst = 1'b1; cpu_ce_i = 1'b1; cpu_addr_i = 8'hFC;
      req_log.delete();
      wait_vld(20);
      chk("wrap_valid", obs_v, 1);
      chk("wrap_inst", obs_i, memw(8'hFC));
      cpu_ce_i = 1'b0;
      repeat (10) cycle();
      chk("wrap_log_n", req_log.size() >= 3, 1);
      if (req_log.size() >= 3) begin
         chk("wrap_log0", req_log[0], 8'hFC);
         chk("wrap_log1", req_log[1], 8'h00);
         chk("wrap_log2", req_log[2], 8'h04);
      end
      cpu_ce_i = 1'b1; cpu_addr_i = 8'h00; cycle();
      chk("wrap_hit0", obs_v, 1);
      cpu_addr_i = 8'h04; cycle();
      chk("wrap_hit4", obs_v, 1);
`ifdef INST_PREFETCH_STATS_EN
      chk("wrap_miss_cnt", miss_cnt_o, 1);
      chk("wrap_hit_cnt", hit_cnt_o, 3);
`endif

      // randomized traffic: random latency, enables, branches and resets
      lat_rnd = 1;
      pc = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 499) != 0);
         if (obs_v) pc = pc + 8'd4;
         if ($urandom_range(0, 15) == 0) pc = 8'($urandom) & 8'hFC;
         cpu_ce_i = ($urandom_range(0, 7) != 0);
         cpu_addr_i = pc;
         cycle();
      end
      rst = 1'b1; cpu_ce_i = 1'b0;
      cycle();
`ifdef INST_PREFETCH_STATS_EN
      chk("rnd_hit_cnt", hit_cnt_o, m_hits);
      chk("rnd_miss_cnt", miss_cnt_o, m_miss);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/inst_prefetch_unit.md
Name: inst_prefetch_unit

Overview:
- Parametrised instruction-fetch front end between the OpenMIPS ROM port (ce/addr/inst) and an instruction memory with variable latency.
- Sequentially prefetches instructions into a DEPTH-entry tagged FIFO and serves hits in the same cycle.
- On a miss it raises stall_req_o, flushes the FIFO, and redirects fetch to the missed address.
- Replaces the fixed zero-latency ROM hookup in the next-generation SOPC.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of 2, at least 2.
- ADDR_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- cpu_ce_i  in  1  CPU fetch enable (rom_ce)
- cpu_addr_i  in  ADDR_W  CPU fetch address
- cpu_inst_o  out  DATA_W  instruction for cpu_addr_i; 0 when not valid
- cpu_valid_o  out  1  cpu_inst_o valid this cycle
- stall_req_o  out  1  pipeline stall request to the CPU
- mem_req_o  out  1  memory read request
- mem_addr_o  out  ADDR_W  memory read address
- mem_ack_i  in  1  memory acknowledge; mem_data_i is valid in this cycle
- mem_data_i  in  DATA_W  memory read data

Behaviour:
- Reset: sampled at the posedge with rst==0.
  - Outputs: mem_req_o=0, mem_addr_o=0, cpu_valid_o=0, cpu_inst_o=0, stall_req_o=0.
  - FIFO is emptied, fetch_ptr=0, state=IDLE, stale=0.
  - A reset in mid-request abandons the request. The memory must tolerate a dropped request.
- FIFO entries hold {tag addr, data}. There are DEPTH entries with wrapping read/write pointers and a count of 0..DEPTH.
- Hit (combinational):
  - Condition: cpu_ce_i=1, FIFO not empty, and head tag == cpu_addr_i.
  - Response: cpu_valid_o=1, cpu_inst_o=head data, stall_req_o=0.
  - The head is popped at the clock edge.
- Bypass:
  - Condition: FIFO empty, mem_ack_i=1, stale=0, and the tag of the returning data == cpu_addr_i.
  - The returning data is forwarded directly (cpu_valid_o=1, no stall) and is not written into the FIFO.
- Miss:
  - Condition: cpu_ce_i=1 and neither a hit nor a bypass.
  - Response: cpu_valid_o=0, stall_req_o=1.
  - If cpu_addr_i differs from the head tag (or from fetch_ptr when the FIFO is empty), the access is a redirect:
    - FIFO flushed at the edge, fetch_ptr <= cpu_addr_i.
    - If a request is outstanding, stale <= 1.
  - If cpu_addr_i equals the expected address, the unit only waits, with no flush.
- cpu_ce_i=0: cpu_valid_o=0, stall_req_o=0, and no pop. Prefetch continues.
- Memory FSM:
  - IDLE: if count + outstanding < DEPTH, go to REQ with mem_req_o=1 and mem_addr_o=fetch_ptr.
  - REQ: mem_req_o and mem_addr_o are held stable until mem_ack_i.
    - On ack with stale=0 (and not bypassed): push {mem_addr_o, mem_data_i}.
    - On ack with stale=1: discard the data and clear stale.
    - In both cases, fetch_ptr <= fetch_ptr + ADDR_STEP (non-stale) and the FSM returns to IDLE.
  - Back-to-back: the FSM may re-enter REQ on the cycle after an ack. At most one request is outstanding.
- Redirect during REQ: mem_req_o stays asserted at the old address until ack (a request is never withdrawn). The next request uses the new fetch_ptr.
- FIFO boundaries:
  - Never push when full; the FSM guarantees this by reserving a slot at issue time.
  - Pop and push in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Address arithmetic is modulo 2^ADDR_W. fetch_ptr wraps from all-ones to 0.
- Latency:
  - Hit: 0 cycles.
  - Redirect miss: the first instruction returns (N+1) cycles after the redirect, where N is the memory ack latency, and is delivered via bypass.

Optional Feature:
- Macro: INST_PREFETCH_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o [31:0] and miss_cnt_o [31:0], both reset to 0.
  - hit_cnt_o increments on each hit or bypass cycle.
  - miss_cnt_o increments once per redirect, not per stall cycle.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then cold start:
  - Stimulus: rst=0 for 2 cycles; release; cpu_ce_i=1, cpu_addr_i=0x0; memory ack latency 2.
  - Response: stall_req_o=1 until the ack; then cpu_valid_o=1 with the data for 0x0 on the ack cycle (bypass).
  - Afterwards the FIFO fills 0x4..0x10 (4 entries).
- Sequential hits:
  - Stimulus: after the FIFO is full, the CPU steps 0x4, 0x8, 0xC on consecutive cycles.
  - Response: cpu_valid_o=1 each cycle, stall_req_o=0, and the instructions match memory contents.
- Branch redirect with a request in flight:
  - Stimulus: while mem_req_o=1 at 0x14, the CPU requests 0x100.
  - Response: mem_addr_o holds 0x14 until ack and that data is discarded; the next mem_addr_o is 0x100.
  - cpu_valid_o for 0x100 arrives only after the 0x100 ack.
- FIFO full back-pressure:
  - Stimulus: cpu_ce_i=0 for 20 cycles.
  - Response: exactly DEPTH=4 acks are accepted; after that mem_req_o=0; count stays at 4.
- Reset mid-operation:
  - Stimulus: assert rst=0 while mem_req_o=1 with count=2.
  - Response: next cycle mem_req_o=0 and cpu_valid_o=0; the next request after release is at 0x0.
- Address wrap (ADDR_W=8):
  - Stimulus: redirect to 0xFC.
  - Response: prefetch addresses are 0xFC, then 0x00, 0x04, and a hit occurs at 0x00.
  - With INST_PREFETCH_STATS_EN: miss_cnt_o=1 and hit_cnt_o increments on each hit.
